dual_issue_stage: RTL and testbench
===================================

# dual_issue_stage

Two-slot, in-order issue register stage directly downstream of the team's 2-in/2-out FIFO. It pops zero, one or two entries per cycle from the FIFO head and holds them in two registered output slots. Slot 0 is always the older entry. It hands them to a dual-lane consumer with per-lane valid/ready, and it guarantees that lane 1 never retires ahead of lane 0.

## Interface
- FIFO_DATA_WIDTH, 32, entry width.
- FIFO_SIZE_WIDTH, 5, log2 of the upstream FIFO depth; occupancy input is FIFO_SIZE_WIDTH+1 bits.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- flush_i  in  1  discard both slots; no pop this cycle.
- stall_i  in  1  block all FIFO pops this cycle; consumer handshakes still complete.
- fifo_num_i  in  FIFO_SIZE_WIDTH+1  current FIFO occupancy.
- fifo_rdata_first_i  in  FIFO_DATA_WIDTH  FIFO head entry.
- fifo_rdata_second_i  in  FIFO_DATA_WIDTH  FIFO head+1 entry.
- fifo_rd_first_en_o  out  1  pop head.
- fifo_rd_second_en_o  out  1  pop head+1; only ever asserted together with fifo_rd_first_en_o.
- out_valid0_o  out  1  slot 0 holds a valid entry.
- out_valid1_o  out  1  slot 1 holds a valid entry.
- out_data0_o  out  FIFO_DATA_WIDTH  slot 0 data (older).
- out_data1_o  out  FIFO_DATA_WIDTH  slot 1 data (younger).
- out_ready0_i  in  1  consumer accepts slot 0.
- out_ready1_i  in  1  consumer accepts slot 1; honoured only when slot 0 is accepted in the same cycle.
- issued_cnt_o  out  32  total accepted entries, wrapping.

## Operation
- State:
  - occ ∈ {0,1,2}. slot1 is valid only if slot0 is valid, so out_valid1_o implies out_valid0_o.
  - out_valid0_o = occ≥1; out_valid1_o = occ==2.
- Accept count acc (combinational):
  - 0 if !(out_valid0_o & out_ready0_i).
  - 2 if out_valid0_o & out_ready0_i & out_valid1_o & out_ready1_i.
  - 1 otherwise.
  - out_ready1_i without out_ready0_i accepts nothing.
- Remaining after accept: rem = occ − acc.
  - If acc==1 and occ==2, slot1 data shifts into slot0.
- Pull count pull (combinational):
  - 0 if flush_i or stall_i.
  - Otherwise min(2 − rem, fifo_num_i), saturated to 2.
  - pull≥1 drives fifo_rd_first_en_o; pull==2 also drives fifo_rd_second_en_o.
  - fifo_rd_second_en_o is never asserted alone.
- Refill at clock edge:
  - rem==0: slot0←fifo_rdata_first_i, and slot1←fifo_rdata_second_i when pull==2.
  - rem==1: slot1←fifo_rdata_first_i.
  - occ_next = rem + pull.
- Flush:
  - occ←0 and slot data is don't-care.
  - Accepts in the flush cycle still count toward issued_cnt_o.
  - pull is forced to 0.
- Counter: issued_cnt_o += acc every non-reset cycle, modulo 2^32.
- Reset (rst) values:
  - occ=0, so out_valid0_o=0 and out_valid1_o=0.
  - out_data0_o=0, out_data1_o=0, issued_cnt_o=0.
  - fifo_rd_first_en_o and fifo_rd_second_en_o are 0 combinationally while rst is high.
  - rst overrides flush_i.

## Timing
- Pop enables are combinational from occ, the ready inputs, fifo_num_i, flush_i, stall_i and rst. There are no registered pops, so no pop-ahead and no over-read.
- Latency:
  - An entry present at the FIFO head with fifo_num_i≥1 in cycle N is popped in cycle N if a slot frees.
  - It appears on out_data*_o with valid in cycle N+1.
- Full throughput: 2 entries per cycle sustained when the consumer accepts both and fifo_num_i≥2.
- Simultaneous accept and refill in one cycle is required; a full stage accepting 2 refills 2 in the same edge.
- Boundaries:
  - fifo_num_i==1 with 2 free slots pops only first.
  - fifo_num_i==0 pops nothing.
  - Stage full with no accept pops nothing.
  - stall_i during accept drains without refilling.
- Ordering: the output sequence equals the FIFO pop order exactly. There is no reordering across slots, including across shifts and partial pops.

## Test plan
- Reset, then FIFO holds A,B,C (fifo_num_i=3) with consumer not ready:
  - Cycle 0 pops 2; cycle 1 shows slot0=A, slot1=B, both valid.
  - No further pops; issued_cnt_o=0.
- Slots A,B with out_ready0_i=1 and out_ready1_i=0, fifo_num_i=1 (C):
  - Next cycle slot0=B, slot1=C, with only fifo_rd_first_en_o pulsed.
  - issued_cnt_o=1.
- Slots A,B with out_ready0_i=0 and out_ready1_i=1:
  - Nothing accepted, no pop, slots unchanged, issued_cnt_o unchanged.
- Streaming 10 entries with both readies high and fifo_num_i≥2:
  - Both pop enables are high every cycle.
  - Entries exit in order at 2 per cycle; issued_cnt_o=10 after the stream.
- flush_i with slots A,B and fifo_num_i=4:
  - No pop that cycle; next cycle both valids are 0.
  - The cycle after that pops 2 and the stage refills.
- rst asserted while full and accepting:
  - Next cycle both valids are 0, pop enables are 0 during reset, and issued_cnt_o=0.

Source files
------------

// File: rtl/dual_issue_stage.sv
// Two-slot in-order issue register fed from a 2-in/2-out FIFO head.
// Slot 0 always holds the older entry; lane 1 only retires alongside lane 0.
module dual_issue_stage #(
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned FIFO_SIZE_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       stall_i,
  input  logic [FIFO_SIZE_WIDTH:0]   fifo_num_i,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_rdata_first_i,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_rdata_second_i,
  output logic                       fifo_rd_first_en_o,
  output logic                       fifo_rd_second_en_o,
  output logic                       out_valid0_o,
  output logic                       out_valid1_o,
  output logic [FIFO_DATA_WIDTH-1:0] out_data0_o,
  output logic [FIFO_DATA_WIDTH-1:0] out_data1_o,
  input  logic                       out_ready0_i,
  input  logic                       out_ready1_i,
  output logic [31:0]                issued_cnt_o
);

  localparam logic [FIFO_SIZE_WIDTH:0] NumTwo = (FIFO_SIZE_WIDTH + 1)'(2);

  logic [1:0]                 occ_q, occ_d;
  logic [FIFO_DATA_WIDTH-1:0] data0_q, data0_d;
  logic [FIFO_DATA_WIDTH-1:0] data1_q, data1_d;
  logic [31:0]                cnt_q, cnt_d;

  logic [1:0] acc, rem, free, avail, pull;

  assign out_valid0_o = (occ_q != 2'd0);
  assign out_valid1_o = (occ_q == 2'd2);
  assign out_data0_o  = data0_q;
  assign out_data1_o  = data1_q;
  assign issued_cnt_o = cnt_q;

  always_comb begin
    acc = 2'd0;
    if (out_valid0_o && out_ready0_i) begin
      acc = (out_valid1_o && out_ready1_i) ? 2'd2 : 2'd1;
    end
    rem   = occ_q - acc;
    free  = 2'd2 - rem;
    avail = (fifo_num_i >= NumTwo) ? 2'd2 : fifo_num_i[1:0];
    pull  = 2'd0;
    if (!rst && !flush_i && !stall_i) begin
      pull = (free < avail) ? free : avail;
    end
    fifo_rd_first_en_o  = (pull != 2'd0);
    fifo_rd_second_en_o = (pull == 2'd2);
  end

  always_comb begin
    occ_d   = rem + pull;
    data0_d = data0_q;
    data1_d = data1_q;
    cnt_d   = cnt_q + 32'(acc);
    if (rem == 2'd0) begin
      if (pull != 2'd0) data0_d = fifo_rdata_first_i;
      if (pull == 2'd2) data1_d = fifo_rdata_second_i;
    end else if (rem == 2'd1) begin
      // One of two accepted: the younger entry moves up to keep slot 0 oldest.
      if (occ_q == 2'd2) data0_d = data1_q;
      if (pull != 2'd0)  data1_d = fifo_rdata_first_i;
    end
    if (flush_i) occ_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      cnt_q   <= 32'd0;
    end else begin
      occ_q   <= occ_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dual_issue_stage.sv
// Randomised and directed bench for dual_issue_stage against a queue-based model
// of the FIFO and of the two issue slots.
module tb_dual_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, stall_i;
  logic [5:0]  fifo_num_i;
  logic [31:0] fifo_rdata_first_i, fifo_rdata_second_i;
  logic        fifo_rd_first_en_o, fifo_rd_second_en_o;
  logic        out_valid0_o, out_valid1_o;
  logic [31:0] out_data0_o, out_data1_o;
  logic        out_ready0_i, out_ready1_i;
  logic [31:0] issued_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] slots_q[$];
  logic [31:0] exp_cnt;
  logic [31:0] next_tag = 32'h1000_0000;

  always #5 clk = ~clk;

  dual_issue_stage #(
    .FIFO_DATA_WIDTH(32),
    .FIFO_SIZE_WIDTH(5)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush_i            (flush_i),
    .stall_i            (stall_i),
    .fifo_num_i         (fifo_num_i),
    .fifo_rdata_first_i (fifo_rdata_first_i),
    .fifo_rdata_second_i(fifo_rdata_second_i),
    .fifo_rd_first_en_o (fifo_rd_first_en_o),
    .fifo_rd_second_en_o(fifo_rd_second_en_o),
    .out_valid0_o       (out_valid0_o),
    .out_valid1_o       (out_valid1_o),
    .out_data0_o        (out_data0_o),
    .out_data1_o        (out_data1_o),
    .out_ready0_i       (out_ready0_i),
    .out_ready1_i       (out_ready1_i),
    .issued_cnt_o       (issued_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_fifo(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_tag);
      next_tag = next_tag + 32'd1;
    end
  endtask

  // Registered outputs compared against the model, sampled mid-cycle.
  task automatic check_outputs();
    chk("valid0", {31'd0, out_valid0_o}, {31'd0, slots_q.size() >= 1});
    chk("valid1", {31'd0, out_valid1_o}, {31'd0, slots_q.size() == 2});
    if (slots_q.size() >= 1) chk("data0", out_data0_o, slots_q[0]);
    if (slots_q.size() == 2) chk("data1", out_data1_o, slots_q[1]);
    chk("issued_cnt", issued_cnt_o, exp_cnt);
  endtask

  task automatic step(input logic r, input logic fl, input logic st,
                      input logic rd0, input logic rd1);
    int acc, pull, room, num;
    @(negedge clk);
    check_outputs();
    num = (fifo_q.size() > 63) ? 63 : fifo_q.size();
    rst = r; flush_i = fl; stall_i = st;
    out_ready0_i = rd0; out_ready1_i = rd1;
    fifo_num_i = 6'(num);
    fifo_rdata_first_i  = (fifo_q.size() >= 1) ? fifo_q[0] : $urandom;
    fifo_rdata_second_i = (fifo_q.size() >= 2) ? fifo_q[1] : $urandom;
    acc = 0;
    if (slots_q.size() >= 1 && rd0) acc = (slots_q.size() == 2 && rd1) ? 2 : 1;
    room = 2 - (slots_q.size() - acc);
    pull = (r || fl || st) ? 0 : ((room < num) ? room : num);
    #1;
    chk("rd_first_en", {31'd0, fifo_rd_first_en_o}, {31'd0, pull >= 1});
    chk("rd_second_en", {31'd0, fifo_rd_second_en_o}, {31'd0, pull == 2});
    if (r) begin
      slots_q.delete();
      exp_cnt = 32'd0;
    end else begin
      exp_cnt = exp_cnt + 32'(acc);
      for (int i = 0; i < acc; i++) void'(slots_q.pop_front());
      for (int i = 0; i < pull; i++) slots_q.push_back(fifo_q.pop_front());
      if (fl) slots_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    out_ready0_i = 1'b0; out_ready1_i = 1'b0;
    fifo_num_i = '0; fifo_rdata_first_i = '0; fifo_rdata_second_i = '0;
    exp_cnt = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_data0", out_data0_o, 32'd0);
    chk("reset_data1", out_data1_o, 32'd0);

    // A,B,C present, consumer idle: two pops, then hold full.
    push_fifo(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Accept slot 0 only with one entry waiting: shift plus single pop.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Ready on lane 1 alone accepts nothing.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Full-rate stream.
    push_fifo(12);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // Stall while accepting drains without refill.
    push_fifo(4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Flush with a backed-up FIFO, then refill.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset while full and accepting.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_cnt", issued_cnt_o, 32'd0);
    chk("post_reset_data0", out_data0_o, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() < 40) push_fifo(int'($urandom_range(0, 3)));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
